// File: rtl/seq_mul_256.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_256
// Purpose  : Sequential shift-and-add unsigned multiplier. Consumes one
//            multiplier bit per clock (LSB first) and produces the full
//            2*B-bit product after exactly B cycles in RUN.
// Ports    : clk     - rising-edge clock for all state
//            rst_n   - synchronous, active-low reset
//            start   - begin a multiplication (sampled only in IDLE)
//            a, b    - B-bit unsigned operands, captured on the accepting edge
//            product - registered 2*B-bit result, held until next completion
//            done    - one-cycle pulse when product has just been updated
//            busy    - high while the multiplier is in RUN
// Revision : 1.0 - initial release
// ============================================================================
module seq_mul_256 #(
    parameter int B = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [B-1:0]   a,
    input  logic [B-1:0]   b,
    output logic [2*B-1:0] product,
    output logic           done,
    output logic           busy
);

    localparam int            C_CW   = (B > 1) ? $clog2(B) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(B - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // The multiplicand is kept pre-shifted: after k steps it equals a << k,
    // so each step adds it unchanged instead of using a wide barrel shifter.
    logic [2*B-1:0] r_mcand;
    // The multiplier shifts right each step; bit 0 is always the bit to use.
    logic [B-1:0]   r_mplier;
    logic [2*B-1:0] r_acc;
    logic [C_CW-1:0] r_cnt;

    logic [2*B-1:0] w_sum;
    logic           w_accept;
    logic           w_last;

    assign w_last = (r_cnt == C_LAST);
    assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : {(2*B){1'b0}});

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // done is a decode of the DONE state, so it is exactly one
                // cycle wide and drops on the unconditional return to IDLE.
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, accumulate, result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            product  <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{B{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_sum;
            r_cnt    <= r_cnt + C_CW'(1);
            // The last partial product goes straight into the result so
            // product updates on the same edge that enters DONE.
            if (w_last) begin
                product <= w_sum;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_256.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mul_256
// Purpose  : Self-checking bench for seq_mul_256. A wide instance (B=256)
//            gets directed scenarios plus random operations; a narrow
//            instance (B=8) gets a long run of random start/operand/reset
//            traffic. Both are compared every cycle against a transaction
//            model that knows only "accept, wait B cycles, publish a*b".
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mul_256;

    localparam int B        = 256;
    localparam int SB       = 8;
    localparam int MAX_WAIT = 600;
    localparam int S_OPS    = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, start;
    logic [B-1:0]   a, b;
    logic [2*B-1:0] product;
    logic           done, busy;

    logic            s_rst_n, s_start;
    logic [SB-1:0]   s_a, s_b;
    logic [2*SB-1:0] s_product;
    logic            s_done, s_busy;

    seq_mul_256 #(.B(B)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .product(product), .done(done), .busy(busy)
    );

    seq_mul_256 #(.B(SB)) dut_s (
        .clk(clk), .rst_n(s_rst_n), .start(s_start), .a(s_a), .b(s_b),
        .product(s_product), .done(s_done), .busy(s_busy)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;
    bit s_finished  = 1'b0;
    int cyc         = 0;

    // Transaction model: phase = edges since accept, -1 when able to accept.
    int             m_phase = -1;
    logic [B-1:0]   m_a, m_b;
    logic [2*B-1:0] m_prod  = '0;
    int              s_phase = -1;
    logic [SB-1:0]   sm_a, sm_b;
    logic [2*SB-1:0] sm_prod = '0;
    int              s_ops   = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_phase = -1;
            m_prod  = '0;
        end else if (m_phase < 0) begin
            if (start) begin
                m_a = a; m_b = b; m_phase = 0;
            end
        end else begin
            m_phase++;
            if (m_phase == B)
                m_prod = {{B{1'b0}}, m_a} * {{B{1'b0}}, m_b};
            else if (m_phase == B + 1)
                m_phase = -1;
        end

        if (!s_rst_n) begin
            s_phase = -1;
            sm_prod = '0;
        end else if (s_phase < 0) begin
            if (s_start) begin
                sm_a = s_a; sm_b = s_b; s_phase = 0;
            end
        end else begin
            s_phase++;
            if (s_phase == SB) begin
                sm_prod = {{SB{1'b0}}, sm_a} * {{SB{1'b0}}, sm_b};
                s_ops++;
            end else if (s_phase == SB + 1) begin
                s_phase = -1;
            end
        end
    end

    // Every-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            vectors++;
            if (product !== m_prod || done !== (m_phase == B) ||
                busy !== (m_phase >= 0 && m_phase < B)) begin
                miscompares++;
                $display("FAIL wide cyc=%0d: product=%h done=%b busy=%b, required product=%h done=%b busy=%b",
                         cyc, product, done, busy, m_prod, (m_phase == B), (m_phase >= 0 && m_phase < B));
            end
            vectors++;
            if (s_product !== sm_prod || s_done !== (s_phase == SB) ||
                s_busy !== (s_phase >= 0 && s_phase < SB)) begin
                miscompares++;
                $display("FAIL narrow cyc=%0d: product=%h done=%b busy=%b, required product=%h done=%b busy=%b",
                         cyc, s_product, s_done, s_busy, sm_prod, (s_phase == SB), (s_phase >= 0 && s_phase < SB));
            end
        end
    end

    task automatic check(input string name, input logic [2*B-1:0] got, input logic [2*B-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    function automatic logic [B-1:0] rnd();
        logic [B-1:0] r;
        for (int i = 0; i < B / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Bounded wait for done at negedges; returns cycle stamp of the pulse.
    task automatic wait_done(input string name, output int t);
        int n;
        n = 0;
        while (done !== 1'b1 && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        if (done !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL %s: done timeout after %0d cycles, required pulse", name, n);
        end
    endtask

    // One operation from IDLE. lat counts edges after the accepting edge up
    // to the done cycle; bsy counts busy cycles before done. Operands are
    // scrambled every cycle after accept; an optional stray start pulse is
    // raised lat==glitch_at cycles into the operation.
    task automatic run_op(input logic [B-1:0] ia, input logic [B-1:0] ib, input int glitch_at,
                          output logic [2*B-1:0] res, output int lat, output int bsy);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib;
        @(negedge clk);
        start = 1'b0; a = rnd(); b = rnd();
        lat = 0; bsy = 0;
        while (done !== 1'b1 && lat < MAX_WAIT) begin
            bsy += int'(busy);
            @(negedge clk);
            lat++;
            start = (lat == glitch_at);
            a = rnd(); b = rnd();
        end
        start = 1'b0;
        res = product;
        if (done !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL run_op: done timeout after %0d cycles, required pulse", lat);
        end
    endtask

    // Narrow instance: random starts, operands every cycle, rare resets.
    initial begin
        int guard;
        s_rst_n = 1'b0; s_start = 1'b0; s_a = '0; s_b = '0;
        repeat (3) @(negedge clk);
        s_rst_n = 1'b1;
        guard = 0;
        while (s_ops < S_OPS && guard < 40000) begin
            @(negedge clk);
            guard++;
            s_start = ($urandom_range(0, 3) != 0);
            s_a     = SB'($urandom);
            s_b     = SB'($urandom);
            s_rst_n = ($urandom_range(0, 199) != 0);
        end
        if (s_ops < S_OPS) begin
            vectors++; miscompares++;
            $display("FAIL narrow_ops: got %0d completed operations, required %0d", s_ops, S_OPS);
        end
        s_finished = 1'b1;
    end

    initial begin
        logic [2*B-1:0] res, exp;
        logic [B-1:0]   ia, ib;
        int lat, bsy, t1, t2, pulses, guard;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        @(posedge clk);
        #1 checking = 1'b1;
        @(negedge clk);
        start = 1'b1; a = '1; b = '1;       // start during reset must be ignored
        @(negedge clk);
        check("reset_product", product, '0);
        check("reset_done", {511'd0, done}, '0);
        check("reset_busy", {511'd0, busy}, '0);
        rst_n = 1'b1; start = 1'b0;

        // 2^255 * 2
        ia = '0; ia[B-1] = 1'b1;
        run_op(ia, 256'd2, -1, res, lat, bsy);
        exp = '0; exp[256] = 1'b1;
        check("pow2_product", res, exp);
        check_int("pow2_latency", lat, 256);
        check_int("pow2_busy_cycles", bsy, 256);

        // all-ones squared: 2^512 - 2^257 + 1
        run_op('1, '1, -1, res, lat, bsy);
        exp = '1; exp = exp << 257; exp = exp + 512'd1;
        check("max_product", res, exp);
        check_int("max_latency", lat, 256);
        @(negedge clk);
        check("max_done_width", {511'd0, done}, '0);

        // zero operand, stray start at cycle 100
        run_op('0, 256'h1234, 100, res, lat, bsy);
        check("zero_product", res, '0);
        check_int("zero_latency", lat, 256);

        // back-to-back with start held high
        @(negedge clk);
        start = 1'b1; a = 256'd3; b = 256'd5;
        @(negedge clk);
        a = 256'd7; b = 256'd11;
        wait_done("b2b_first", t1);
        check("b2b_first_product", product, 512'd15);
        @(negedge clk);
        wait_done("b2b_second", t2);
        start = 1'b0;
        check("b2b_second_product", product, 512'd77);
        check_int("b2b_period", t2 - t1, 258);

        // reset 50 cycles into RUN
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = rnd(); b = rnd();
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_product", product, '0);
        check("abort_busy", {511'd0, busy}, '0);
        pulses = 0;
        repeat (300) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check_int("abort_done_pulses", pulses, 0);
        run_op(256'd6, 256'd7, -1, res, lat, bsy);
        check("after_reset_product", res, 512'd42);

        // random wide operations
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 5))
                0:       ia = '0;
                1:       ia = '1;
                default: ia = rnd();
            endcase
            ib = ($urandom_range(0, 5) == 0) ? '1 : rnd();
            run_op(ia, ib, $urandom_range(0, 255), res, lat, bsy);
            exp = {{B{1'b0}}, ia} * {{B{1'b0}}, ib};
            check("random_product", res, exp);
            check_int("random_latency", lat, 256);
        end

        guard = 0;
        while (!s_finished && guard < 50000) begin
            @(negedge clk);
            guard++;
        end
        if (!s_finished) begin
            vectors++; miscompares++;
            $display("FAIL narrow_finish: got unfinished, required finished");
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
